sim_halt_ctrl: RTL and testbench

SIM_HALT_CTRL -- requirements
Module: sim_halt_ctrl

---
 rtl/sim_ctrl_pkg.sv | 31 +++
 rtl/sim_wdog.sv | 37 +++
 rtl/sim_halt_ctrl.sv | 143 ++++++++++++++
 tb/tb_sim_halt_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_ctrl_pkg.sv
// sim_ctrl_pkg: shared types and constants for the simulation halt controller.
//   state_e      - controller state encoding (RUN, DRAIN, HALT)
//   HALT_*       - halt_code values reported on halt_code
//   EBREAK_INST  - instruction word that requests the end of simulation
//   cnt_width()  - bit width needed to hold a count 0..max_val (minimum 1)
package sim_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  typedef logic [1:0] halt_code_t;

  localparam halt_code_t HALT_NONE    = 2'd0;
  localparam halt_code_t HALT_GOOD    = 2'd1;
  localparam halt_code_t HALT_BAD     = 2'd2;
  localparam halt_code_t HALT_TIMEOUT = 2'd3;

  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

  // Width of a counter that must represent every value in 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    if (max_val < 2) begin
      return 1;
    end
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sim_wdog.sv
// sim_wdog: commit watchdog.
//   clk, rst_n   - clock, synchronous active-low reset
//   i_clear      - a commit was seen; restart the idle count
//   i_enable     - count this cycle (controller is in RUN)
//   o_expired_c  - combinational: this cycle is idle cycle number LIMIT
// The counter saturates at LIMIT so it can never wrap if left enabled.
module sim_wdog
  import sim_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired_c
);

  logic [WIDTH-1:0] r_cnt;

  // Idle-cycle counter: cleared by commits, frozen when not enabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != WIDTH'(LIMIT))) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  // Expiry is flagged on the cycle whose increment would reach LIMIT, so the
  // controller halts on exactly the LIMIT-th idle edge.
  assign o_expired_c = i_enable && !i_clear && (r_cnt == WIDTH'(LIMIT - 1));

endmodule

// File: rtl/sim_halt_ctrl.sv
// sim_halt_ctrl: ends a simulation on an ebreak commit or a commit timeout.
//   clk, rst_n    - clock, synchronous active-low reset
//   commit_valid  - one instruction retires this cycle
//   commit_inst   - retiring instruction word
//   commit_pc     - retiring instruction PC
//   gpr_a0        - current architectural x10 value
//   stall_req     - freezes core fetch/commit (DRAIN and HALT)
//   halt          - simulation finished, sticky until reset
//   halt_code     - 0 none, 1 good trap, 2 bad trap, 3 timeout
//   halt_pc       - ebreak PC, or last committed PC on timeout
//   halt_a0       - x10 captured at halt
//   cycle_cnt     - cycles since reset (RUN and DRAIN)
//   inst_cnt      - instructions committed in RUN since reset
module sim_halt_ctrl
  import sim_ctrl_pkg::*;
#(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned WDOG_CYCLES  = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            commit_valid,
  input  logic [31:0]     commit_inst,
  input  logic [XLEN-1:0] commit_pc,
  input  logic [XLEN-1:0] gpr_a0,
  output logic            stall_req,
  output logic            halt,
  output logic [1:0]      halt_code,
  output logic [XLEN-1:0] halt_pc,
  output logic [XLEN-1:0] halt_a0,
  output logic [63:0]     cycle_cnt,
  output logic [63:0]     inst_cnt
);

  localparam int unsigned DRAIN_W = cnt_width(DRAIN_CYCLES);
  localparam int unsigned WDOG_W  = cnt_width(WDOG_CYCLES);

  state_e              r_state;
  logic [DRAIN_W-1:0]  r_drain_cnt;
  logic [XLEN-1:0]     r_last_pc;
  logic                r_stall;
  logic                r_halt;
  halt_code_t          r_halt_code;
  logic [XLEN-1:0]     r_halt_pc;
  logic [XLEN-1:0]     r_halt_a0;
  logic [63:0]         r_cycle_cnt;
  logic [63:0]         r_inst_cnt;

  logic                w_in_run;
  logic                w_run_commit;
  logic                w_ebreak;
  logic                w_wdog_expired;
  logic                w_drain_done;

  assign w_in_run     = (r_state == ST_RUN);
  assign w_run_commit = w_in_run && commit_valid;
  assign w_ebreak     = w_run_commit && (commit_inst == EBREAK_INST);
  assign w_drain_done = (r_drain_cnt == '0);

  // Idle-commit watchdog: only counts in RUN, any RUN commit restarts it.
  sim_wdog #(
    .WIDTH (WDOG_W),
    .LIMIT (WDOG_CYCLES)
  ) u_wdog (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_run_commit),
    .i_enable    (w_in_run),
    .o_expired_c (w_wdog_expired)
  );

  // Controller FSM with registered outputs and counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= '0;
      r_last_pc   <= '0;
      r_stall     <= 1'b0;
      r_halt      <= 1'b0;
      r_halt_code <= HALT_NONE;
      r_halt_pc   <= '0;
      r_halt_a0   <= '0;
      r_cycle_cnt <= '0;
      r_inst_cnt  <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_cycle_cnt <= r_cycle_cnt + 64'd1;
          if (w_run_commit) begin
            r_inst_cnt <= r_inst_cnt + 64'd1;
            r_last_pc  <= commit_pc;
          end
          // An ebreak takes priority over a simultaneous watchdog expiry.
          if (w_ebreak) begin
            r_halt_pc   <= commit_pc;
            r_drain_cnt <= DRAIN_W'(DRAIN_CYCLES);
            r_stall     <= 1'b1;
            r_state     <= ST_DRAIN;
          end else if (w_wdog_expired) begin
            r_halt_pc   <= r_last_pc;
            r_halt_a0   <= gpr_a0;
            r_halt_code <= HALT_TIMEOUT;
            r_halt      <= 1'b1;
            r_stall     <= 1'b1;
            r_state     <= ST_HALT;
          end
        end

        ST_DRAIN: begin
          // Core is stalled: commits are ignored, only time advances.
          r_cycle_cnt <= r_cycle_cnt + 64'd1;
          if (w_drain_done) begin
            r_halt_a0   <= gpr_a0;
            r_halt_code <= (gpr_a0 == '0) ? HALT_GOOD : HALT_BAD;
            r_halt      <= 1'b1;
            r_state     <= ST_HALT;
          end else begin
            r_drain_cnt <= r_drain_cnt - DRAIN_W'(1);
          end
        end

        ST_HALT: begin
          // Absorbing: everything holds until reset.
        end

        default: begin
          r_state <= ST_HALT;
          r_stall <= 1'b1;
        end
      endcase
    end
  end

  assign stall_req = r_stall;
  assign halt      = r_halt;
  assign halt_code = r_halt_code;
  assign halt_pc   = r_halt_pc;
  assign halt_a0   = r_halt_a0;
  assign cycle_cnt = r_cycle_cnt;
  assign inst_cnt  = r_inst_cnt;

endmodule

// File: tb/tb_sim_halt_ctrl.sv
// tb_sim_halt_ctrl: table-driven bench for sim_halt_ctrl with a halt scoreboard.
module tb_sim_halt_ctrl;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned DRAIN = 4;
  localparam int unsigned WDOG  = 1024;
  localparam int          BOUND = 2000;
  localparam logic [31:0] EBRK  = 32'h0010_0073;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic            clk;
  logic            rst_n;
  logic            commit_valid;
  logic [31:0]     commit_inst;
  logic [XLEN-1:0] commit_pc;
  logic [XLEN-1:0] gpr_a0;
  logic            stall_req;
  logic            halt;
  logic [1:0]      halt_code;
  logic [XLEN-1:0] halt_pc;
  logic [XLEN-1:0] halt_a0;
  logic [63:0]     cycle_cnt;
  logic [63:0]     inst_cnt;

  int checks;
  int failures;

  sim_halt_ctrl #(
    .XLEN         (XLEN),
    .DRAIN_CYCLES (DRAIN),
    .WDOG_CYCLES  (WDOG)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .commit_valid (commit_valid),
    .commit_inst  (commit_inst),
    .commit_pc    (commit_pc),
    .gpr_a0       (gpr_a0),
    .stall_req    (stall_req),
    .halt         (halt),
    .halt_code    (halt_code),
    .halt_pc      (halt_pc),
    .halt_a0      (halt_a0),
    .cycle_cnt    (cycle_cnt),
    .inst_cnt     (inst_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One scenario: n_pre nops from pc0, then optionally an ebreak.
  typedef struct {
    logic [63:0] a0;
    logic [63:0] pc0;
    int          n_pre;
    logic        ebrk;
    logic [1:0]  code;
    logic [63:0] hpc;
    logic [63:0] inst;
    logic [63:0] cyc;
    int          lat;
  } vec_t;

  typedef struct {
    logic [1:0]  code;
    logic [63:0] pc;
    logic [63:0] a0;
    logic [63:0] inst;
    logic [63:0] cyc;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    commit_valid = 1'b0;
    commit_inst  = 32'h0;
    commit_pc    = '0;
  endtask

  task automatic commit(input logic [31:0] inst, input logic [63:0] pc);
    commit_valid = 1'b1;
    commit_inst  = inst;
    commit_pc    = pc;
    tick();
  endtask

  // Reset for two edges, check cleared state, release so the next edge is RUN cycle 1.
  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    chk({nm, "_rst_halt"},  64'(halt),      64'd0);
    chk({nm, "_rst_stall"}, 64'(stall_req), 64'd0);
    chk({nm, "_rst_code"},  64'(halt_code), 64'd0);
    chk({nm, "_rst_pc"},    halt_pc,        64'd0);
    chk({nm, "_rst_a0"},    halt_a0,        64'd0);
    chk({nm, "_rst_cyc"},   cycle_cnt,      64'd0);
    chk({nm, "_rst_inst"},  inst_cnt,       64'd0);
    rst_n = 1'b1;
  endtask

  task automatic cmp_exp(input string nm, input exp_t e);
    chk({nm, "_halt"}, 64'(halt),      64'd1);
    chk({nm, "_stall"},64'(stall_req), 64'd1);
    chk({nm, "_code"}, 64'(halt_code), 64'(e.code));
    chk({nm, "_pc"},   halt_pc,        e.pc);
    chk({nm, "_a0"},   halt_a0,        e.a0);
    chk({nm, "_inst"}, inst_cnt,       e.inst);
    chk({nm, "_cyc"},  cycle_cnt,      e.cyc);
  endtask

  // Wait (bounded) for halt, pop the scoreboard, then confirm HALT ignores inputs.
  task automatic wait_halt(input string nm, input int lat, input logic drain_commits);
    exp_t e;
    int   k;
    logic seen;
    seen = 1'b0;
    k    = 0;
    while (!seen && (k < BOUND)) begin
      if (drain_commits) begin
        commit_valid = 1'b1;
        commit_inst  = (k == 2) ? EBRK : NOP;
        commit_pc    = 64'h9000_0000 + 64'(4 * k);
      end
      tick();
      k++;
      if (halt === 1'b1) seen = 1'b1;
    end
    chk({nm, "_halt_seen"}, 64'(seen), 64'd1);
    chk({nm, "_latency"},   64'(k),    64'(lat));
    if (sb.size() == 0) begin
      chk({nm, "_sb_entry"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      cmp_exp(nm, e);
      commit_valid = 1'b1;
      commit_inst  = EBRK;
      commit_pc    = 64'hDEAD_0000;
      gpr_a0       = ~e.a0;
      repeat (3) tick();
      cmp_exp({nm, "_frozen"}, e);
    end
    idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    exp_t e;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    gpr_a0   = '0;
    idle_inputs();

    // a0, pc0, n_pre, ebrk, code, halt_pc, inst_cnt, cycle_cnt, latency
    vecs[0] = '{64'h0, 64'h8000_0000, 4, 1'b1, 2'd1, 64'h8000_0010, 64'd5,  64'd10,   5};
    vecs[1] = '{64'h1, 64'h8000_0018, 2, 1'b1, 2'd2, 64'h8000_0020, 64'd3,  64'd8,    5};
    vecs[2] = '{64'h0, 64'h8000_1000, 9, 1'b1, 2'd1, 64'h8000_1024, 64'd10, 64'd15,   5};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000, 0, 1'b1, 2'd2, 64'h8000_0000,
                64'd1, 64'd6, 5};
    vecs[4] = '{64'h55, 64'h8000_0100, 1, 1'b0, 2'd3, 64'h8000_0100, 64'd1, 64'd1025, 1024};
    vecs[5] = '{64'h0, 64'h0, 0, 1'b0, 2'd3, 64'h0, 64'd0, 64'd1024, 1024};

    for (int i = 0; i < 6; i++) begin
      string nm;
      nm = $sformatf("v%0d", i);
      do_reset(nm);
      gpr_a0 = vecs[i].a0;
      for (int j = 0; j < vecs[i].n_pre; j++) begin
        commit(NOP, vecs[i].pc0 + 64'(4 * j));
      end
      if (vecs[i].ebrk) begin
        commit(EBRK, vecs[i].pc0 + 64'(4 * vecs[i].n_pre));
        chk({nm, "_drain_stall"}, 64'(stall_req), 64'd1);
        chk({nm, "_drain_nohalt"}, 64'(halt), 64'd0);
      end
      idle_inputs();
      e = '{vecs[i].code, vecs[i].hpc, vecs[i].a0, vecs[i].inst, vecs[i].cyc};
      sb.push_back(e);
      wait_halt(nm, vecs[i].lat, vecs[i].ebrk);
    end

    // Ebreak on the very cycle the watchdog would expire: DRAIN wins.
    do_reset("coinc");
    gpr_a0 = '0;
    commit(NOP, 64'h8000_0200);
    idle_inputs();
    repeat (WDOG - 1) tick();
    chk("coinc_pre_halt",  64'(halt),      64'd0);
    chk("coinc_pre_stall", 64'(stall_req), 64'd0);
    commit(EBRK, 64'h8000_0204);
    idle_inputs();
    chk("coinc_drain_stall", 64'(stall_req), 64'd1);
    chk("coinc_drain_nohalt", 64'(halt), 64'd0);
    chk("coinc_drain_code", 64'(halt_code), 64'd0);
    e = '{2'd1, 64'h8000_0204, 64'h0, 64'd2, 64'(1 + (WDOG - 1) + 1 + DRAIN + 1)};
    sb.push_back(e);
    wait_halt("coinc", 5, 1'b1);

    // Reset asserted during the second DRAIN cycle.
    do_reset("mdr");
    gpr_a0 = 64'h7;
    commit(NOP, 64'h8000_0300);
    commit(NOP, 64'h8000_0304);
    commit(NOP, 64'h8000_0308);
    commit(EBRK, 64'h8000_030C);
    idle_inputs();
    tick();
    rst_n = 1'b0;
    tick();
    chk("mdr_stall", 64'(stall_req), 64'd0);
    chk("mdr_halt",  64'(halt),      64'd0);
    chk("mdr_cyc",   cycle_cnt,      64'd0);
    chk("mdr_inst",  inst_cnt,       64'd0);
    chk("mdr_pc",    halt_pc,        64'd0);
    rst_n = 1'b1;
    tick();
    chk("mdr_first_cyc",   cycle_cnt,      64'd1);
    chk("mdr_first_stall", 64'(stall_req), 64'd0);
    repeat (6) tick();
    chk("mdr_no_resume_halt", 64'(halt), 64'd0);
    chk("mdr_later_cyc",      cycle_cnt, 64'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
